// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_add_if.sv
// Operand/result valid-ready bundle for serial_add_seq.
// Optional macro SERIAL_ADD_OVF_EN adds the ovf result signal.
interface serial_add_if
    import serial_add_pkg::*;
#(
    parameter int W = SA_W_DEFAULT
);

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] sum;
    logic         co;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;

    modport master (
        output s_valid, a, b, ci, m_ready,
        input  s_ready, m_valid, sum, co, ovf
    );

    modport slave (
        input  s_valid, a, b, ci, m_ready,
        output s_ready, m_valid, sum, co, ovf
    );
`else
    modport master (
        output s_valid, a, b, ci, m_ready,
        input  s_ready, m_valid, sum, co
    );

    modport slave (
        input  s_valid, a, b, ci, m_ready,
        output s_ready, m_valid, sum, co
    );
`endif

endinterface

// File: rtl/serial_add_seq_full_adder.sv
// Single-bit full adder shared by every bit position
// of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full_adder reused LSB first over W cycles.
// Optional macro SERIAL_ADD_OVF_EN adds signed overflow output.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int W = SA_W_DEFAULT
) (
    input logic         clk,
    input logic         rstn,
    serial_add_if.slave bus
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q;
    logic [W-1:0]  a_sh_q;
    logic [W-1:0]  b_sh_q;
    logic [W-1:0]  sum_sh_q;
    logic          carry_q;
    logic [CW-1:0] bit_cnt_q;
    logic          fa_sum;
    logic          fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic          cin_msb_q;
`endif

    full_adder u_fa (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .ci  (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            carry_q   <= 1'b0;
            bit_cnt_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
            cin_msb_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.s_valid) begin
                        a_sh_q    <= bus.a;
                        b_sh_q    <= bus.b;
                        carry_q   <= bus.ci;
                        sum_sh_q  <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q    <= a_sh_q >> 1;
                    b_sh_q    <= b_sh_q >> 1;
                    sum_sh_q  <= {fa_sum, sum_sh_q[W-1:1]};
                    carry_q   <= fa_co;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    if (bit_cnt_q == LAST) begin
                        state_q <= DONE;
`ifdef SERIAL_ADD_OVF_EN
                        // carry entering the MSB, kept for overflow
                        cin_msb_q <= carry_q;
`endif
                    end
                end
                DONE: begin
                    if (bus.m_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = (state_q == IDLE);
    assign bus.m_valid = (state_q == DONE);
    assign bus.sum     = sum_sh_q;
    assign bus.co      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf     = cin_msb_q ^ carry_q;
`endif

endmodule
